// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared definitions for the reset sequencer: FSM state encoding,
// the bit positions of the sticky reset-cause register and a small
// elaboration-time helper.
package reset_seq_pkg;

  // Sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Bit positions inside rst_cause.
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_EXT = 3;

  // Larger of two integers; sizes the shared hold/stagger counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
// Multi-stage flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears every stage to 0
//   d   - asynchronous input
//   q   - synchronized output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the input one stage further each clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// reset_seq
// Reset sequencer. Merges power-on reset with firmware, watchdog and
// external-pin reset requests and produces two staged active-low domain
// resets: peripherals are released first, the CPU STAGGER_CYCLES later.
// A sticky cause register records what triggered the last reset.
// Ports:
//   clk          - system clock
//   rst          - power-on reset, asynchronous, active-high
//   sw_rst_req   - firmware reset request (synchronous, level)
//   wdt_rst_req  - watchdog expiry (synchronous, level)
//   ext_rst_req  - external reset request (asynchronous, active-high)
//   cause_clr    - clears rst_cause, honoured only in RUN
//   periph_rst_n - peripheral domain reset, active-low, registered
//   cpu_rst_n    - CPU domain reset, active-low, registered
//   rst_busy     - high whenever the sequencer is not in RUN
//   rst_cause    - sticky cause {EXT, WDT, SW, POR}
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 64,
  parameter int STAGGER_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       ext_rst_req,
  input  logic       cause_clr,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       rst_busy,
  output logic [3:0] rst_cause
);

  localparam int CTR_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES));
  localparam logic [CTR_W-1:0] HOLD_LAST    = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] STAGGER_LAST = CTR_W'(STAGGER_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             periph_q, periph_d;
  logic             cpu_q, cpu_d;
  logic             busy_q, busy_d;
  logic [3:0]       cause_q, cause_d;

  logic       ext_sync;
  logic [3:0] req_bits;
  logic       req;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_req),
    .q   (ext_sync)
  );

  // Request vector laid out to match rst_cause; the POR bit is never a request.
  always_comb begin
    req_bits            = 4'b0000;
    req_bits[CAUSE_SW]  = sw_rst_req;
    req_bits[CAUSE_WDT] = wdt_rst_req;
    req_bits[CAUSE_EXT] = ext_sync;
    req                 = |req_bits;
  end

  // Next-state logic: a request always restarts HOLD, ahead of any terminal count.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    periph_d = periph_q;
    cpu_d    = cpu_q;
    cause_d  = cause_q;
    if (req) begin
      state_d  = HOLD;
      ctr_d    = '0;
      periph_d = 1'b0;
      cpu_d    = 1'b0;
      // A fresh event from RUN replaces the record; a restart accumulates.
      if (state_q == RUN) begin
        cause_d = req_bits;
      end else begin
        cause_d = cause_q | req_bits;
      end
    end else begin
      case (state_q)
        HOLD: begin
          if (ctr_q == HOLD_LAST) begin
            state_d  = STAGGER;
            ctr_d    = '0;
            periph_d = 1'b1;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        STAGGER: begin
          if (ctr_q == STAGGER_LAST) begin
            state_d = RUN;
            ctr_d   = '0;
            cpu_d   = 1'b1;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        RUN: begin
          if (cause_clr) begin
            cause_d = 4'b0000;
          end else begin
            cause_d = cause_q;
          end
        end
        default: begin
          state_d  = HOLD;
          ctr_d    = '0;
          periph_d = 1'b0;
          cpu_d    = 1'b0;
        end
      endcase
    end
    // Busy is registered from the next state so it falls with cpu_rst_n.
    busy_d = (state_d != RUN);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HOLD;
      ctr_q    <= '0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      busy_q   <= 1'b1;
      cause_q  <= 4'b0001;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      busy_q   <= busy_d;
      cause_q  <= cause_d;
    end
  end

  assign periph_rst_n = periph_q;
  assign cpu_rst_n    = cpu_q;
  assign rst_busy     = busy_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq
// Directed self-checking bench for reset_seq with default parameters
// (HOLD 64, STAGGER 16, SYNC 2). Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point.
module tb_reset_seq;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       ext_rst_req;
  logic       cause_clr;
  logic       periph_rst_n;
  logic       cpu_rst_n;
  logic       rst_busy;
  logic [3:0] rst_cause;

  int checks   = 0;
  int failures = 0;

  reset_seq #(
    .HOLD_CYCLES    (64),
    .STAGGER_CYCLES (16),
    .SYNC_STAGES    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_rst_req   (sw_rst_req),
    .wdt_rst_req  (wdt_rst_req),
    .ext_rst_req  (ext_rst_req),
    .cause_clr    (cause_clr),
    .periph_rst_n (periph_rst_n),
    .cpu_rst_n    (cpu_rst_n),
    .rst_busy     (rst_busy),
    .rst_cause    (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ticks(3);
    checks++; if (periph_rst_n !== 1'b0) begin failures++; $display("FAIL por_periph_in_rst got=%b exp=0", periph_rst_n); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL por_cpu_in_rst got=%b exp=0", cpu_rst_n); end
    checks++; if (rst_busy !== 1'b1) begin failures++; $display("FAIL por_busy_in_rst got=%b exp=1", rst_busy); end
    checks++; if (rst_cause !== 4'b0001) begin failures++; $display("FAIL por_cause_in_rst got=%b exp=0001", rst_cause); end
    rst = 1'b0;
    ticks(63);
    checks++; if (periph_rst_n !== 1'b0) begin failures++; $display("FAIL por_periph_e63 got=%b exp=0", periph_rst_n); end
    ticks(1);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL por_periph_e64 got=%b exp=1", periph_rst_n); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL por_cpu_e64 got=%b exp=0", cpu_rst_n); end
    ticks(15);
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL por_cpu_e79 got=%b exp=0", cpu_rst_n); end
    checks++; if (rst_busy !== 1'b1) begin failures++; $display("FAIL por_busy_e79 got=%b exp=1", rst_busy); end
    ticks(1);
    checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL por_cpu_e80 got=%b exp=1", cpu_rst_n); end
    checks++; if (rst_busy !== 1'b0) begin failures++; $display("FAIL por_busy_e80 got=%b exp=0", rst_busy); end
    checks++; if (rst_cause !== 4'b0001) begin failures++; $display("FAIL por_cause_e80 got=%b exp=0001", rst_cause); end
  endtask

  task automatic test_sw_req;
    sw_rst_req = 1'b1;
    ticks(1);
    sw_rst_req = 1'b0;
    checks++; if (periph_rst_n !== 1'b0 || cpu_rst_n !== 1'b0) begin failures++; $display("FAIL sw_resets_low got=%b%b exp=00", periph_rst_n, cpu_rst_n); end
    checks++; if (rst_busy !== 1'b1) begin failures++; $display("FAIL sw_busy got=%b exp=1", rst_busy); end
    checks++; if (rst_cause !== 4'b0010) begin failures++; $display("FAIL sw_cause got=%b exp=0010", rst_cause); end
    ticks(63);
    checks++; if (periph_rst_n !== 1'b0) begin failures++; $display("FAIL sw_periph_63 got=%b exp=0", periph_rst_n); end
    ticks(1);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL sw_periph_64 got=%b exp=1", periph_rst_n); end
    ticks(15);
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL sw_cpu_79 got=%b exp=0", cpu_rst_n); end
    ticks(1);
    checks++; if (cpu_rst_n !== 1'b1 || rst_busy !== 1'b0) begin failures++; $display("FAIL sw_cpu_80 got=cpu%b busy%b exp=cpu1 busy0", cpu_rst_n, rst_busy); end
  endtask

  task automatic test_stagger_restart;
    sw_rst_req = 1'b1;
    ticks(1);
    sw_rst_req = 1'b0;
    ticks(64);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL stg_periph_up got=%b exp=1", periph_rst_n); end
    ticks(5);
    wdt_rst_req = 1'b1;
    ticks(1);
    wdt_rst_req = 1'b0;
    checks++; if (periph_rst_n !== 1'b0 || cpu_rst_n !== 1'b0) begin failures++; $display("FAIL stg_restart_low got=%b%b exp=00", periph_rst_n, cpu_rst_n); end
    checks++; if (rst_cause !== 4'b0110) begin failures++; $display("FAIL stg_cause got=%b exp=0110", rst_cause); end
    ticks(63);
    checks++; if (periph_rst_n !== 1'b0) begin failures++; $display("FAIL stg_periph_63 got=%b exp=0", periph_rst_n); end
    ticks(1);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL stg_periph_64 got=%b exp=1", periph_rst_n); end
    ticks(15);
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL stg_cpu_79 got=%b exp=0", cpu_rst_n); end
    ticks(1);
    checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL stg_cpu_80 got=%b exp=1", cpu_rst_n); end
  endtask

  task automatic test_ext_sync;
    ext_rst_req = 1'b1;
    ticks(2);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL ext_early_fall got=%b exp=1", periph_rst_n); end
    ticks(1);
    ext_rst_req = 1'b0;
    checks++; if (periph_rst_n !== 1'b0 || cpu_rst_n !== 1'b0) begin failures++; $display("FAIL ext_fall_e3 got=%b%b exp=00", periph_rst_n, cpu_rst_n); end
    checks++; if (rst_cause !== 4'b1000) begin failures++; $display("FAIL ext_cause got=%b exp=1000", rst_cause); end
    // Synchronized request is last sampled at pin edge 5, so release is at 69.
    ticks(65);
    checks++; if (periph_rst_n !== 1'b0) begin failures++; $display("FAIL ext_periph_68 got=%b exp=0", periph_rst_n); end
    ticks(1);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL ext_periph_69 got=%b exp=1", periph_rst_n); end
    ticks(16);
    checks++; if (cpu_rst_n !== 1'b1 || rst_cause !== 4'b1000) begin failures++; $display("FAIL ext_cpu_85 got=cpu%b cause%b exp=cpu1 cause1000", cpu_rst_n, rst_cause); end
  endtask

  task automatic test_cause_clr;
    cause_clr = 1'b1;
    ticks(1);
    cause_clr = 1'b0;
    checks++; if (rst_cause !== 4'b0000) begin failures++; $display("FAIL clr_alone got=%b exp=0000", rst_cause); end
    checks++; if (rst_busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", rst_busy); end
    cause_clr  = 1'b1;
    sw_rst_req = 1'b1;
    ticks(1);
    sw_rst_req = 1'b0;
    checks++; if (rst_cause !== 4'b0010) begin failures++; $display("FAIL clr_vs_sw got=%b exp=0010", rst_cause); end
    checks++; if (periph_rst_n !== 1'b0 || rst_busy !== 1'b1) begin failures++; $display("FAIL clr_vs_sw_seq got=periph%b busy%b exp=periph0 busy1", periph_rst_n, rst_busy); end
    ticks(1);
    cause_clr = 1'b0;
    checks++; if (rst_cause !== 4'b0010) begin failures++; $display("FAIL clr_in_hold got=%b exp=0010", rst_cause); end
    ticks(79);
    checks++; if (cpu_rst_n !== 1'b1 || rst_busy !== 1'b0) begin failures++; $display("FAIL clr_seq_end got=cpu%b busy%b exp=cpu1 busy0", cpu_rst_n, rst_busy); end
  endtask

  task automatic test_async_mid_hold;
    sw_rst_req = 1'b1;
    ticks(1);
    sw_rst_req = 1'b0;
    ticks(30);
    checks++; if (rst_cause !== 4'b0010) begin failures++; $display("FAIL arst_pre_cause got=%b exp=0010", rst_cause); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rst_cause !== 4'b0001) begin failures++; $display("FAIL arst_cause_async got=%b exp=0001", rst_cause); end
    checks++; if (periph_rst_n !== 1'b0 || cpu_rst_n !== 1'b0 || rst_busy !== 1'b1) begin failures++; $display("FAIL arst_outs got=%b%b%b exp=001", periph_rst_n, cpu_rst_n, rst_busy); end
    rst = 1'b0;
    // Counter restarted from 0, so a full 64-edge hold follows.
    ticks(63);
    checks++; if (periph_rst_n !== 1'b0) begin failures++; $display("FAIL arst_periph_63 got=%b exp=0", periph_rst_n); end
    ticks(1);
    checks++; if (periph_rst_n !== 1'b1) begin failures++; $display("FAIL arst_periph_64 got=%b exp=1", periph_rst_n); end
    ticks(16);
    checks++; if (cpu_rst_n !== 1'b1 || rst_busy !== 1'b0) begin failures++; $display("FAIL arst_cpu_80 got=cpu%b busy%b exp=cpu1 busy0", cpu_rst_n, rst_busy); end
  endtask

  initial begin
    rst         = 1'b1;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    ext_rst_req = 1'b0;
    cause_clr   = 1'b0;
    test_reset();
    test_sw_req();
    test_stagger_restart();
    test_ext_sync();
    test_cause_clr();
    test_async_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
